// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the uP16 MEM stage, the debug/DMA loader and the data RAM.
// The arbiter takes the slave view; the requesters and the RAM model take the master view.
interface dmem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_ack;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_stall,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_ack, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_stall,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_ack, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter for the uP16 core: CPU/DMA arbitration with DMA anti-starvation,
// IDLE/ISSUE/WAIT/DONE access sequencing. Optional perf counters under ARB_PERF_CNT_EN.
module dmem_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int DMA_STARVE = 4
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [15:0]   cpu_stall_cnt,
  output logic [15:0]   dma_grant_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DMA = 1'b1} owner_t;

  localparam int SW = $clog2(DMA_STARVE + 1);

  state_t            state_r, state_s;
  owner_t            owner_r, owner_s;
  logic [2:0]        wait_r, wait_s;
  logic [SW-1:0]     starve_r, starve_s;
  logic              capture_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic              cpu_stall_s;

  logic              mem_en_r, mem_we_r, cpu_ack_r, dma_ack_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r, rdata_r;

  // State, owner, wait and starve registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      owner_r  <= OWN_CPU;
      wait_r   <= 3'd0;
      starve_r <= '0;
    end else begin
      state_r  <= state_s;
      owner_r  <= owner_s;
      wait_r   <= wait_s;
      starve_r <= starve_s;
    end
  end

  // Next-state, arbitration and starve-counter logic
  always_comb begin
    state_s   = state_r;
    owner_s   = owner_r;
    wait_s    = wait_r;
    starve_s  = starve_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        // With both pending a CPU grant implies starve_r < DMA_STARVE, so +1 saturates by construction.
        if (bus.cpu_req && (!bus.dma_req || starve_r != SW'(DMA_STARVE))) begin
          owner_s = OWN_CPU;
          state_s = ISSUE;
          if (bus.dma_req) begin
            starve_s = starve_r + SW'(1);
          end else begin
            starve_s = '0;
          end
        end else if (bus.dma_req) begin
          owner_s  = OWN_DMA;
          state_s  = ISSUE;
          starve_s = '0;
        end else begin
          starve_s = '0;
        end
      end
      ISSUE: begin
        if ((owner_r == OWN_DMA) ? bus.dma_we : bus.cpu_we) begin
          state_s = DONE;
        end else begin
          wait_s  = 3'(MEM_LAT);
          state_s = WAIT;
        end
      end
      WAIT: begin
        wait_s = wait_r - 3'd1;
        if (wait_r == 3'd1) begin
          capture_s = 1'b1;
          state_s   = DONE;
        end else begin
          capture_s = 1'b0;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Memory-side source select for the access about to be issued
  always_comb begin
    if (owner_s == OWN_DMA) begin
      sel_we_s    = bus.dma_we;
      sel_addr_s  = bus.dma_addr;
      sel_wdata_s = bus.dma_wdata;
    end else begin
      sel_we_s    = bus.cpu_we;
      sel_addr_s  = bus.cpu_addr;
      sel_wdata_s = bus.cpu_wdata;
    end
  end

  // Registered outputs are computed from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      cpu_ack_r   <= 1'b0;
      dma_ack_r   <= 1'b0;
      rdata_r     <= '0;
    end else begin
      mem_en_r    <= (state_s == ISSUE);
      mem_we_r    <= (state_s == ISSUE) && sel_we_s;
      mem_addr_r  <= (state_s == ISSUE) ? sel_addr_s : '0;
      mem_wdata_r <= (state_s == ISSUE) ? sel_wdata_s : '0;
      cpu_ack_r   <= (state_s == DONE) && (owner_s == OWN_CPU);
      dma_ack_r   <= (state_s == DONE) && (owner_s == OWN_DMA);
      if (capture_s) begin
        rdata_r <= bus.mem_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign cpu_stall_s   = bus.cpu_req & ~cpu_ack_r;
  assign bus.cpu_stall = cpu_stall_s;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.dma_ack   = dma_ack_r;
  assign bus.cpu_rdata = rdata_r;
  assign bus.dma_rdata = rdata_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

`ifdef ARB_PERF_CNT_EN
  logic        dma_grant_s;
  logic [15:0] stall_cnt_r, grant_cnt_r;

  assign dma_grant_s = (state_r == IDLE) && (state_s == ISSUE) && (owner_s == OWN_DMA);

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
      grant_cnt_r <= 16'h0000;
    end else begin
      if (cpu_stall_s && stall_cnt_r != 16'hFFFF) begin
        stall_cnt_r <= stall_cnt_r + 16'h0001;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (dma_grant_s && grant_cnt_r != 16'hFFFF) begin
        grant_cnt_r <= grant_cnt_r + 16'h0001;
      end else begin
        grant_cnt_r <= grant_cnt_r;
      end
    end
  end

  assign cpu_stall_cnt = stall_cnt_r;
  assign dma_grant_cnt = grant_cnt_r;
`else
  assign cpu_stall_cnt = 16'h0000;
  assign dma_grant_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: dut_a runs MEM_LAT=1 against a RAM model,
// dut_b runs MEM_LAT=4 against an address-derived read pattern.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef ARB_PERF_CNT_EN
  localparam logic [15:0] EXP_STALL_A = 16'd20;
  localparam logic [15:0] EXP_STALL_B = 16'd6;
  localparam logic [15:0] EXP_GRANT_A = 16'd1;
`else
  localparam logic [15:0] EXP_STALL_A = 16'd0;
  localparam logic [15:0] EXP_STALL_B = 16'd0;
  localparam logic [15:0] EXP_GRANT_A = 16'd0;
`endif

  int n_vec = 0;
  int n_err = 0;

  dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus_a ();
  dmem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus_b ();
  logic [15:0] stall_cnt_a, grant_cnt_a, stall_cnt_b, grant_cnt_b;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(1), .DMA_STARVE(4)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a),
    .cpu_stall_cnt(stall_cnt_a), .dma_grant_cnt(grant_cnt_a)
  );
  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MEM_LAT(4), .DMA_STARVE(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b),
    .cpu_stall_cnt(stall_cnt_b), .dma_grant_cnt(grant_cnt_b)
  );

  // RAM model for dut_a: one-cycle read latency, 0xDEAD outside the valid slot
  logic [15:0] mem_a [256];
  logic [15:0] pipe_a;
  always @(posedge clk) begin
    if (bus_a.mem_en && bus_a.mem_we) mem_a[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
    pipe_a <= (bus_a.mem_en && !bus_a.mem_we) ? mem_a[bus_a.mem_addr[7:0]] : 16'hDEAD;
  end
  assign bus_a.mem_rdata = pipe_a;

  // Read model for dut_b: four-cycle latency, data = addr ^ 0x5A5A
  logic [15:0] pipe_b [4];
  always @(posedge clk) begin
    pipe_b[0] <= (bus_b.mem_en && !bus_b.mem_we) ? (bus_b.mem_addr ^ 16'h5A5A) : 16'hDEAD;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    pipe_b[3] <= pipe_b[2];
  end
  assign bus_b.mem_rdata = pipe_b[3];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One CPU access on dut_a; lat = cycles from request to ack, 0 on timeout
  task automatic do_cpu(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        output int lat);
    lat = 0;
    bus_a.cpu_req   = 1'b1;
    bus_a.cpu_we    = we;
    bus_a.cpu_addr  = addr;
    bus_a.cpu_wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus_a.cpu_ack) begin
        lat = c;
        break;
      end
    end
    bus_a.cpu_req = 1'b0;
    step();
  endtask

  int          lat;
  int          en_cnt;
  int          n_ack;
  logic [5:0]  order;
  logic        stall_at_dma;

  initial begin
    rst = 1'b1;
    bus_a.cpu_req = 1'b0; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h0000; bus_a.cpu_wdata = 16'h0000;
    bus_a.dma_req = 1'b0; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'h0000; bus_a.dma_wdata = 16'h0000;
    bus_b.cpu_req = 1'b0; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h0000; bus_b.cpu_wdata = 16'h0000;
    bus_b.dma_req = 1'b0; bus_b.dma_we = 1'b0; bus_b.dma_addr = 16'h0000; bus_b.dma_wdata = 16'h0000;
    step();
    step();
    rst = 1'b0;

    check("rst_mem_en", {31'd0, bus_a.mem_en}, 32'd0);
    check("rst_mem_we", {31'd0, bus_a.mem_we}, 32'd0);
    check("rst_cpu_ack", {31'd0, bus_a.cpu_ack}, 32'd0);
    check("rst_dma_ack", {31'd0, bus_a.dma_ack}, 32'd0);
    check("rst_rdata", {16'd0, bus_a.cpu_rdata}, 32'd0);
    check("rst_stall_cnt", {16'd0, stall_cnt_a}, 32'd0);

    // CPU write 0x0010 <= 0xBEEF
    bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b1; bus_a.cpu_addr = 16'h0010; bus_a.cpu_wdata = 16'hBEEF;
    #1;
    check("wr_stall_c0", {31'd0, bus_a.cpu_stall}, 32'd1);
    check("wr_en_c0", {31'd0, bus_a.mem_en}, 32'd0);
    step();
    check("wr_en_c1", {31'd0, bus_a.mem_en}, 32'd1);
    check("wr_we_c1", {31'd0, bus_a.mem_we}, 32'd1);
    check("wr_addr_c1", {16'd0, bus_a.mem_addr}, 32'h0010);
    check("wr_wdata_c1", {16'd0, bus_a.mem_wdata}, 32'hBEEF);
    check("wr_stall_c1", {31'd0, bus_a.cpu_stall}, 32'd1);
    check("wr_ack_c1", {31'd0, bus_a.cpu_ack}, 32'd0);
    step();
    check("wr_ack_c2", {31'd0, bus_a.cpu_ack}, 32'd1);
    check("wr_en_c2", {31'd0, bus_a.mem_en}, 32'd0);
    check("wr_stall_c2", {31'd0, bus_a.cpu_stall}, 32'd0);
    bus_a.cpu_req = 1'b0;
    step();
    check("wr_ack_c3", {31'd0, bus_a.cpu_ack}, 32'd0);

    // CPU read 0x0010, MEM_LAT=1
    bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b0; bus_a.cpu_addr = 16'h0010;
    step();
    check("rd_en_c1", {31'd0, bus_a.mem_en}, 32'd1);
    check("rd_we_c1", {31'd0, bus_a.mem_we}, 32'd0);
    check("rd_addr_c1", {16'd0, bus_a.mem_addr}, 32'h0010);
    step();
    check("rd_ack_c2", {31'd0, bus_a.cpu_ack}, 32'd0);
    check("rd_en_c2", {31'd0, bus_a.mem_en}, 32'd0);
    step();
    check("rd_ack_c3", {31'd0, bus_a.cpu_ack}, 32'd1);
    check("rd_data_c3", {16'd0, bus_a.cpu_rdata}, 32'hBEEF);
    bus_a.cpu_req = 1'b0;
    step();
    check("rd_ack_c4", {31'd0, bus_a.cpu_ack}, 32'd0);
    check("rd_data_hold", {16'd0, bus_a.cpu_rdata}, 32'hBEEF);

    // MEM_LAT=4 read on dut_b
    bus_b.cpu_req = 1'b1; bus_b.cpu_we = 1'b0; bus_b.cpu_addr = 16'h0020;
    lat = 0;
    en_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (bus_b.mem_en) en_cnt++;
      if (bus_b.cpu_ack) begin
        lat = c;
        break;
      end
    end
    bus_b.cpu_req = 1'b0;
    check("lat4_ack_cycle", lat, 32'd6);
    check("lat4_en_cycles", en_cnt, 32'd1);
    check("lat4_rdata", {16'd0, bus_b.cpu_rdata}, 32'h5A7A);
    check("lat4_stall_cnt", {16'd0, stall_cnt_b}, {16'd0, EXP_STALL_B});
    check("lat4_grant_cnt", {16'd0, grant_cnt_b}, 32'd0);
    step();

    // Both requesters held: CPU x4, then DMA, then CPU
    bus_a.cpu_req = 1'b1; bus_a.cpu_we = 1'b1; bus_a.cpu_addr = 16'h0030; bus_a.cpu_wdata = 16'h1111;
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b1; bus_a.dma_addr = 16'h0040; bus_a.dma_wdata = 16'h2222;
    order = 6'b000000;
    n_ack = 0;
    stall_at_dma = 1'b0;
    for (int c = 0; c < 80 && n_ack < 6; c++) begin
      step();
      if (bus_a.cpu_ack || bus_a.dma_ack) begin
        order = {order[4:0], bus_a.dma_ack};
        n_ack++;
        if (bus_a.dma_ack) stall_at_dma = bus_a.cpu_stall;
      end
    end
    bus_a.cpu_req = 1'b0;
    bus_a.dma_req = 1'b0;
    step();
    check("starve_n_ack", n_ack, 32'd6);
    check("starve_order", {26'd0, order}, 32'h02);
    check("stall_during_dma", {31'd0, stall_at_dma}, 32'd1);
    check("dma_grant_cnt", {16'd0, grant_cnt_a}, {16'd0, EXP_GRANT_A});
    check("rdata_hold_on_wr", {16'd0, bus_a.cpu_rdata}, 32'hBEEF);

    // Reset during the WAIT phase of a DMA read
    bus_a.dma_req = 1'b1; bus_a.dma_we = 1'b0; bus_a.dma_addr = 16'h0044;
    step();
    check("dma_rd_en", {31'd0, bus_a.mem_en}, 32'd1);
    check("dma_rd_addr", {16'd0, bus_a.mem_addr}, 32'h0044);
    step();
    check("dma_rd_wait_en", {31'd0, bus_a.mem_en}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_a.dma_req = 1'b0;
    check("rst_wait_dma_ack", {31'd0, bus_a.dma_ack}, 32'd0);
    check("rst_wait_mem_en", {31'd0, bus_a.mem_en}, 32'd0);
    check("rst_wait_rdata", {16'd0, bus_a.cpu_rdata}, 32'd0);
    step();
    check("rst_wait_no_ack", {31'd0, bus_a.dma_ack}, 32'd0);
    do_cpu(1'b1, 16'h0011, 16'h1357, lat);
    check("post_rst_wr_lat", lat, 32'd2);
    do_cpu(1'b0, 16'h0011, 16'h0000, lat);
    check("post_rst_rd_lat", lat, 32'd3);
    check("post_rst_rd_data", {16'd0, bus_a.cpu_rdata}, 32'h1357);

    // Ten CPU writes from a fresh reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("perf_rst_cnt", {16'd0, stall_cnt_a}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      do_cpu(1'b1, 16'h0080 + 16'(i), 16'hA000 + 16'(i), lat);
      check("perf_wr_lat", lat, 32'd2);
    end
    check("perf_stall_cnt", {16'd0, stall_cnt_a}, {16'd0, EXP_STALL_A});
    check("perf_grant_cnt", {16'd0, grant_cnt_a}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
